// File: rtl/response_reorder_buffer_pkg.sv
// Shared widths and depth for the response reorder buffer and its match CAM.
package response_reorder_buffer_pkg;

    localparam int RROB_DEPTH = 8;
    localparam int ID_WIDTH   = 8;
    localparam int DATA_WIDTH = 8;

endpackage

// File: rtl/response_reorder_buffer_match_cam.sv
// Purely combinational CAM: finds the oldest allocated, unfilled entry whose ID matches,
// scanning with rotating priority starting at the head slot.
module rrob_match_cam #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3,
    parameter int ID_W  = 8
) (
    input  logic [DEPTH-1:0]      i_alloc,
    input  logic [DEPTH-1:0]      i_filled,
    input  logic [DEPTH*ID_W-1:0] i_id_flat,
    input  logic [PTR_W-1:0]      i_head,
    input  logic [ID_W-1:0]       i_match_id,
    output logic                  o_hit,
    output logic [PTR_W-1:0]      o_hit_idx
);

    logic [DEPTH-1:0] w_cand;

    always_comb begin
        w_cand = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_cand[i] = i_alloc[i] && !i_filled[i] && (i_id_flat[i*ID_W +: ID_W] == i_match_id);
        end
    end

    // Walk from youngest to oldest so the slot nearest the head is the last one written.
    always_comb begin
        logic [PTR_W-1:0] w_idx;
        o_hit     = 1'b0;
        o_hit_idx = '0;
        w_idx     = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            w_idx = i_head + PTR_W'(k);
            if (w_cand[w_idx]) begin
                o_hit     = 1'b1;
                o_hit_idx = w_idx;
            end
        end
    end

endmodule

// File: rtl/response_reorder_buffer.sv
// Returns out-of-order responses to the consumer in original issue order.
// Optional macro RROB_BYPASS_EN: a response for the unfilled head is presented in the same cycle.
module response_reorder_buffer
    import response_reorder_buffer_pkg::*;
#(
    parameter int DEPTH = RROB_DEPTH,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ID_WIDTH-1:0]   in_issue_id,
    input  logic                  in_issue_valid,
    output logic                  out_issue_stall,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [ID_WIDTH-1:0]   in_id,
    input  logic                  in_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ID_WIDTH-1:0]   out_id,
    output logic                  out_valid,
    input  logic                  in_stall,
    output logic                  out_orphan
);

    logic [DEPTH-1:0]      r_alloc;
    logic [DEPTH-1:0]      r_filled;
    logic [ID_WIDTH-1:0]   r_id   [DEPTH];
    logic [DATA_WIDTH-1:0] r_data [DEPTH];
    logic [PTR_W:0]        r_head;
    logic [PTR_W:0]        r_tail;
    logic                  r_orphan;

    logic [PTR_W-1:0]       w_head_idx;
    logic [PTR_W-1:0]       w_tail_idx;
    logic [PTR_W:0]         w_count;
    logic                   w_full;
    logic                   w_issue;
    logic                   w_hit;
    logic [PTR_W-1:0]       w_hit_idx;
    logic [DEPTH*ID_WIDTH-1:0] w_id_flat;
    logic                   w_head_ready;
    logic                   w_bypass;
    logic                   w_pop;
    logic                   w_fill;

    assign w_head_idx      = r_head[PTR_W-1:0];
    assign w_tail_idx      = r_tail[PTR_W-1:0];
    assign w_count         = r_tail - r_head;
    assign w_full          = (w_count == (PTR_W+1)'(DEPTH));
    assign out_issue_stall = w_full;
    assign w_issue         = in_issue_valid && !w_full;
    assign out_orphan      = r_orphan;

    always_comb begin
        w_id_flat = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_id_flat[i*ID_WIDTH +: ID_WIDTH] = r_id[i];
        end
    end

    rrob_match_cam #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W),
        .ID_W  (ID_WIDTH)
    ) u_match_cam (
        .i_alloc    (r_alloc),
        .i_filled   (r_filled),
        .i_id_flat  (w_id_flat),
        .i_head     (w_head_idx),
        .i_match_id (in_id),
        .o_hit      (w_hit),
        .o_hit_idx  (w_hit_idx)
    );

    assign w_head_ready = r_alloc[w_head_idx] && r_filled[w_head_idx];

`ifdef RROB_BYPASS_EN
    // A CAM hit on the head slot means the head is allocated, unfilled and ID-matched.
    assign w_bypass  = in_valid && w_hit && (w_hit_idx == w_head_idx) && !w_head_ready;
    assign out_valid = w_head_ready || w_bypass;
    assign out_data  = w_bypass ? in_data : r_data[w_head_idx];
    assign out_id    = w_bypass ? in_id   : r_id[w_head_idx];
`else
    assign w_bypass  = 1'b0;
    assign out_valid = w_head_ready;
    assign out_data  = r_data[w_head_idx];
    assign out_id    = r_id[w_head_idx];
`endif

    assign w_pop  = out_valid && !in_stall;
    assign w_fill = in_valid && w_hit && !(w_bypass && w_pop);

    // Fill, pop and issue always address distinct slots, so their writes never collide.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_alloc  <= '0;
            r_filled <= '0;
            r_head   <= '0;
            r_tail   <= '0;
            r_orphan <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_id[i]   <= '0;
                r_data[i] <= '0;
            end
        end else begin
            if (w_fill) begin
                r_filled[w_hit_idx] <= 1'b1;
                r_data[w_hit_idx]   <= in_data;
            end
            if (w_pop) begin
                r_alloc[w_head_idx]  <= 1'b0;
                r_filled[w_head_idx] <= 1'b0;
                r_head               <= r_head + 1'b1;
            end
            if (w_issue) begin
                r_alloc[w_tail_idx]  <= 1'b1;
                r_filled[w_tail_idx] <= 1'b0;
                r_id[w_tail_idx]     <= in_issue_id;
                r_tail               <= r_tail + 1'b1;
            end
            if (in_valid && !w_hit) begin
                r_orphan <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_response_reorder_buffer.sv
// Directed self-checking bench for response_reorder_buffer (default build, RROB_BYPASS_EN aware).
module tb_response_reorder_buffer;
    import response_reorder_buffer_pkg::*;

`ifdef RROB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                  clk;
    logic                  reset;
    logic [ID_WIDTH-1:0]   in_issue_id;
    logic                  in_issue_valid;
    logic                  out_issue_stall;
    logic [DATA_WIDTH-1:0] in_data;
    logic [ID_WIDTH-1:0]   in_id;
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic [ID_WIDTH-1:0]   out_id;
    logic                  out_valid;
    logic                  in_stall;
    logic                  out_orphan;

    int testsRun;
    int testsFailed;

    response_reorder_buffer dut (
        .clk             (clk),
        .reset           (reset),
        .in_issue_id     (in_issue_id),
        .in_issue_valid  (in_issue_valid),
        .out_issue_stall (out_issue_stall),
        .in_data         (in_data),
        .in_id           (in_id),
        .in_valid        (in_valid),
        .out_data        (out_data),
        .out_id          (out_id),
        .out_valid       (out_valid),
        .in_stall        (in_stall),
        .out_orphan      (out_orphan)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic issueId(input logic [ID_WIDTH-1:0] id);
        in_issue_valid = 1'b1;
        in_issue_id    = id;
        step();
        in_issue_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        in_issue_valid = 1'b0; in_issue_id = '0;
        in_valid = 1'b0; in_id = '0; in_data = '0; in_stall = 1'b0;
        #2;
        testsRun++; if (out_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_valid: got %b expected 0", out_valid); end
        testsRun++; if (out_data !== 8'h00) begin testsFailed++; $display("[TB] FAIL reset_data: got %h expected 00", out_data); end
        testsRun++; if (out_id !== 8'h00) begin testsFailed++; $display("[TB] FAIL reset_id: got %h expected 00", out_id); end
        testsRun++; if (out_issue_stall !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_stall: got %b expected 0", out_issue_stall); end
        testsRun++; if (out_orphan !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_orphan: got %b expected 0", out_orphan); end
        @(negedge clk);
        reset = 1'b1;
        step();
    endtask

    task automatic test_in_order();
        int expId;
        bit expValid;
        issueId(8'd1); issueId(8'd2); issueId(8'd3);
        for (int k = 0; k < 5; k++) begin
            in_valid = (k < 3);
            in_id    = 8'(k + 1);
            in_data  = 8'((k + 1) * 16);
            mid();
            expId    = BYP ? k + 1 : k;
            expValid = (expId >= 1) && (expId <= 3);
            testsRun++; if (out_valid !== expValid) begin testsFailed++; $display("[TB] FAIL inorder_valid c%0d: got %b expected %b", k, out_valid, expValid); end
            if (expValid) begin
                testsRun++; if (out_id !== 8'(expId)) begin testsFailed++; $display("[TB] FAIL inorder_id c%0d: got %h expected %h", k, out_id, 8'(expId)); end
                testsRun++; if (out_data !== 8'(expId * 16)) begin testsFailed++; $display("[TB] FAIL inorder_data c%0d: got %h expected %h", k, out_data, 8'(expId * 16)); end
            end
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reorder();
        int rspSeq [3] = '{6, 4, 5};
        int expDef [6] = '{0, 0, 4, 5, 6, 0};
        int expByp [6] = '{0, 4, 5, 6, 0, 0};
        int expId;
        issueId(8'd4); issueId(8'd5); issueId(8'd6);
        for (int k = 0; k < 6; k++) begin
            in_valid = (k < 3);
            in_id    = (k < 3) ? 8'(rspSeq[k]) : 8'h00;
            in_data  = (k < 3) ? 8'(rspSeq[k] * 16 + 1) : 8'h00;
            mid();
            expId = BYP ? expByp[k] : expDef[k];
            testsRun++; if (out_valid !== (expId != 0)) begin testsFailed++; $display("[TB] FAIL reorder_valid c%0d: got %b expected %b", k, out_valid, (expId != 0)); end
            if (expId != 0) begin
                testsRun++; if (out_id !== 8'(expId)) begin testsFailed++; $display("[TB] FAIL reorder_id c%0d: got %h expected %h", k, out_id, 8'(expId)); end
                testsRun++; if (out_data !== 8'(expId * 16 + 1)) begin testsFailed++; $display("[TB] FAIL reorder_data c%0d: got %h expected %h", k, out_data, 8'(expId * 16 + 1)); end
            end
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_full();
        for (int i = 0; i < 8; i++) begin
            mid();
            testsRun++; if (out_issue_stall !== 1'b0) begin testsFailed++; $display("[TB] FAIL full_prestall i%0d: got %b expected 0", i, out_issue_stall); end
            issueId(8'(8'h20 + i));
        end
        mid();
        testsRun++; if (out_issue_stall !== 1'b1) begin testsFailed++; $display("[TB] FAIL full_stall: got %b expected 1", out_issue_stall); end
        issueId(8'h30);
        in_stall = 1'b1; in_valid = 1'b1; in_id = 8'h20; in_data = 8'h55;
        step();
        in_valid = 1'b0;
        mid();
        testsRun++; if (out_issue_stall !== 1'b1) begin testsFailed++; $display("[TB] FAIL full_stall_held: got %b expected 1", out_issue_stall); end
        testsRun++; if (out_id !== 8'h20 || out_valid !== 1'b1) begin testsFailed++; $display("[TB] FAIL full_head: got %h/%b expected 20/1", out_id, out_valid); end
        in_stall = 1'b0;
        step();
        mid();
        testsRun++; if (out_issue_stall !== 1'b0) begin testsFailed++; $display("[TB] FAIL full_release: got %b expected 0", out_issue_stall); end
        step();
        for (int i = 1; i < 8; i++) begin
            in_valid = 1'b1; in_id = 8'(8'h20 + i); in_data = 8'(i);
            step();
        end
        in_valid = 1'b0;
        repeat (3) step();
        mid();
        testsRun++; if (out_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL full_drained: got %b expected 0", out_valid); end
        testsRun++; if (out_orphan !== 1'b0) begin testsFailed++; $display("[TB] FAIL full_no_orphan: got %b expected 0", out_orphan); end
        step();
    endtask

    task automatic test_back_pressure();
        issueId(8'h07); issueId(8'h08);
        in_stall = 1'b1; in_valid = 1'b1; in_id = 8'h07; in_data = 8'hA5;
        step();
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            mid();
            testsRun++; if (out_valid !== 1'b1 || out_id !== 8'h07 || out_data !== 8'hA5) begin testsFailed++; $display("[TB] FAIL bp_hold c%0d: got %b/%h/%h expected 1/07/a5", c, out_valid, out_id, out_data); end
            step();
        end
        in_stall = 1'b0;
        step();
        mid();
        testsRun++; if (out_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL bp_single_pop: got %b expected 0", out_valid); end
        in_stall = 1'b1;
        step();
        in_valid = 1'b1; in_id = 8'h08; in_data = 8'h88;
        step();
        in_valid = 1'b0;
        mid();
        testsRun++; if (out_valid !== 1'b1 || out_id !== 8'h08 || out_data !== 8'h88) begin testsFailed++; $display("[TB] FAIL bp_next_head: got %b/%h/%h expected 1/08/88", out_valid, out_id, out_data); end
        in_stall = 1'b0;
        step();
        step();
    endtask

    task automatic test_orphan_dup();
        in_valid = 1'b1; in_id = 8'h09; in_data = 8'hEE;
        step();
        in_valid = 1'b0;
        mid();
        testsRun++; if (out_orphan !== 1'b1) begin testsFailed++; $display("[TB] FAIL orphan_set: got %b expected 1", out_orphan); end
        testsRun++; if (out_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL orphan_dropped: got %b expected 0", out_valid); end
        repeat (3) step();
        mid();
        testsRun++; if (out_orphan !== 1'b1) begin testsFailed++; $display("[TB] FAIL orphan_sticky: got %b expected 1", out_orphan); end
        issueId(8'h02); issueId(8'h02);
        in_stall = 1'b1;
        in_valid = 1'b1; in_id = 8'h02; in_data = 8'h11;
        step();
        in_data = 8'h22;
        step();
        in_valid = 1'b0;
        mid();
        testsRun++; if (out_valid !== 1'b1 || out_data !== 8'h11) begin testsFailed++; $display("[TB] FAIL dup_first: got %b/%h expected 1/11", out_valid, out_data); end
        in_stall = 1'b0;
        step();
        mid();
        testsRun++; if (out_valid !== 1'b1 || out_data !== 8'h22) begin testsFailed++; $display("[TB] FAIL dup_second: got %b/%h expected 1/22", out_valid, out_data); end
        step();
        mid();
        testsRun++; if (out_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL dup_empty: got %b expected 0", out_valid); end
        step();
    endtask

    task automatic test_reset_mid_op();
        issueId(8'h41); issueId(8'h42); issueId(8'h43);
        in_stall = 1'b1; in_valid = 1'b1; in_id = 8'h41; in_data = 8'h77;
        step();
        in_valid = 1'b0;
        mid();
        testsRun++; if (out_valid !== 1'b1) begin testsFailed++; $display("[TB] FAIL rst_pre_valid: got %b expected 1", out_valid); end
        #2 reset = 1'b0;
        #1;
        testsRun++; if (out_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL rst_async_valid: got %b expected 0", out_valid); end
        testsRun++; if (out_orphan !== 1'b0) begin testsFailed++; $display("[TB] FAIL rst_async_orphan: got %b expected 0", out_orphan); end
        in_stall = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        step();
        mid();
        testsRun++; if (out_issue_stall !== 1'b0 || out_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL rst_after: got %b/%b expected 0/0", out_issue_stall, out_valid); end
        in_valid = 1'b1; in_id = 8'h42; in_data = 8'h00;
        step();
        in_valid = 1'b0;
        mid();
        testsRun++; if (out_orphan !== 1'b1) begin testsFailed++; $display("[TB] FAIL rst_discarded: got %b expected 1", out_orphan); end
        step();
    endtask

`ifdef RROB_BYPASS_EN
    task automatic test_bypass();
        issueId(8'h50);
        in_valid = 1'b1; in_id = 8'h50; in_data = 8'h5A;
        mid();
        testsRun++; if (out_valid !== 1'b1 || out_data !== 8'h5A) begin testsFailed++; $display("[TB] FAIL bypass_same_cycle: got %b/%h expected 1/5a", out_valid, out_data); end
        step();
        in_valid = 1'b0;
        mid();
        testsRun++; if (out_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL bypass_popped: got %b expected 0", out_valid); end
        step();
    endtask
`endif

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        test_reset();
        test_in_order();
        test_reorder();
        test_full();
        test_back_pressure();
`ifdef RROB_BYPASS_EN
        test_bypass();
`endif
        test_orphan_dup();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
